// File: rtl/proc_cfg_pkg.sv
// Shared encodings for the processor configuration sequencer:
// FSM states, mode codes, register map and kernel tap selection.
package proc_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOF,
    WR_KER,
    WR_MODE,
    RD_MODE,
    CHK
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_INVERT  = 2'b01,
    MODE_CONV    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  localparam logic [4:0] ADDR_MODE = 5'h00;
  localparam logic [4:0] ADDR_K0   = 5'h04;
  localparam int         NUM_TAPS  = 9;
  localparam int         KER_W     = 8 * NUM_TAPS;

  function automatic logic [7:0] kernel_tap(input logic [KER_W-1:0] kernel,
                                            input logic [3:0] k);
    logic [KER_W-1:0] shifted;
    shifted = kernel >> {k, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic is_hold_state(input seq_state_t s);
    return s inside {WR_KER, WR_MODE, RD_MODE, CHK};
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Pixel position within a frame; advances the edge after en, wraps after the last pixel.
// No backpressure of its own: en low freezes the count.
module frame_pos_counter #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT,
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = (count == CNT_W'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/proc_cfg_seq.sv
// Frame-aligned processor reconfiguration: writes kernel/mode, reads mode back, reports done/err.
// Writes start the cycle after acceptance (idle frame) or frame end; req_ready low and pix_hold high while busy.
module proc_cfg_seq
  import proc_cfg_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  input  logic [71:0] req_kernel,
  input  logic        pix_valid,
  output logic        pix_hold,
  output logic        reg_write_en,
  output logic [4:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic [1:0]  cur_mode,
  output logic        done,
  output logic        err
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  seq_state_t       state_q, state_d;
  logic [3:0]       k_q;
  mode_t            mode_q;
  logic [KER_W-1:0] kernel_q;
  logic [CNT_W-1:0] pix_count;
  logic             pix_last;
  logic             accept, illegal_accept, mismatch;
  logic             unused_rdata;

  frame_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk   (clk),
    .resetn(resetn),
    .en    (pix_valid & ~pix_hold),
    .count (pix_count),
    .last  (pix_last)
  );

  assign req_ready      = (state_q == IDLE);
  assign accept         = req_valid && req_ready;
  assign illegal_accept = accept && (mode_t'(req_mode) == MODE_ILLEGAL);
  assign mismatch       = (reg_rdata[1:0] != mode_q);
  // Only the two mode bits are architecturally defined in the readback.
  assign unused_rdata   = ^reg_rdata[7:2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !illegal_accept) begin
          if (pix_count == '0 && !pix_valid) begin
            state_d = (mode_t'(req_mode) == MODE_CONV) ? WR_KER : WR_MODE;
          end else begin
            state_d = WAIT_EOF;
          end
        end
      end
      WAIT_EOF: begin
        if (pix_last && pix_valid) begin
          state_d = (mode_q == MODE_CONV) ? WR_KER : WR_MODE;
        end
      end
      WR_KER:  if (k_q == 4'(NUM_TAPS - 1)) state_d = WR_MODE;
      WR_MODE: state_d = RD_MODE;
      RD_MODE: state_d = CHK;
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_write_en = 1'b0;
    reg_addr     = ADDR_MODE;
    reg_wdata    = '0;
    case (state_q)
      WR_KER: begin
        reg_write_en = 1'b1;
        reg_addr     = ADDR_K0 + {1'b0, k_q};
        reg_wdata    = kernel_tap(kernel_q, k_q);
      end
      WR_MODE: begin
        reg_write_en = 1'b1;
        reg_wdata    = {6'b0, mode_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      k_q      <= '0;
      mode_q   <= MODE_BYPASS;
      kernel_q <= '0;
      pix_hold <= 1'b0;
      cur_mode <= MODE_BYPASS;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= (state_q == WR_KER) ? k_q + 4'd1 : 4'd0;
      pix_hold <= is_hold_state(state_d);
      done     <= (state_q == CHK) || illegal_accept;
      err      <= ((state_q == CHK) && mismatch) || illegal_accept;
      if (accept) begin
        mode_q   <= mode_t'(req_mode);
        kernel_q <= req_kernel;
      end
      if (state_q == CHK && !mismatch) begin
        cur_mode <= mode_q;
      end
    end
  end

endmodule

// File: doc/proc_cfg_seq.md
PROC_CFG_SEQ -- requirements
Module: proc_cfg_seq

Interface
REQ-001 Parameter IMG_WIDTH, default 32, pixels per line of the processed image.
REQ-002 Parameter IMG_HEIGHT, default 32, lines per frame.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  configuration request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_mode  input  2  requested mode: 00 bypass, 01 invert, 10 convolution, 11 illegal.
REQ-008 req_kernel  input  72  nine signed 8-bit weights; weight k in bits [8k+7:8k].
REQ-009 pix_valid  input  1  a pixel is consumed by the processor this cycle.
REQ-010 pix_hold  output  1  system shall block FIFO reads while high.
REQ-011 reg_write_en  output  1  processor register write strobe.
REQ-012 reg_addr  output  5  processor register address.
REQ-013 reg_wdata  output  8  processor register write data.
REQ-014 reg_rdata  input  8  processor register read data, valid one cycle after reg_addr.
REQ-015 cur_mode  output  2  last mode committed and verified.
REQ-016 done  output  1  one-cycle pulse: request finished.
REQ-017 err  output  1  one-cycle pulse with done: illegal mode or readback mismatch.

Function
REQ-018 req_ready shall be high only in IDLE; a request is accepted on req_valid && req_ready, capturing req_mode and req_kernel.
REQ-019 States: IDLE, WAIT_EOF, WR_KER, WR_MODE, RD_MODE, CHK.
REQ-020 Pixel counter shall increment on pix_valid, wrap from IMG_WIDTH*IMG_HEIGHT-1 to 0, and hold while pix_hold is high.
REQ-021 On acceptance with counter==0 and pix_valid low, go directly to WR_KER (mode 10) or WR_MODE (other modes); otherwise go to WAIT_EOF.
REQ-022 WAIT_EOF shall exit in the cycle the last pixel of the frame is consumed (count==W*H-1 && pix_valid) to WR_KER or WR_MODE.
REQ-023 pix_hold shall be registered, high in every cycle of WR_KER, WR_MODE, RD_MODE and CHK, low otherwise.
REQ-024 WR_KER: 9 consecutive cycles, reg_write_en=1, reg_addr=0x04+k, reg_wdata=weight k, k=0..8; then WR_MODE.
REQ-025 WR_MODE: one cycle, reg_write_en=1, reg_addr=0x00, reg_wdata={6'b0,mode}; then RD_MODE.
REQ-026 RD_MODE: reg_write_en=0, reg_addr=0x00; CHK compares reg_rdata[1:0] with mode.
REQ-027 On match in CHK, cur_mode shall update to mode; on mismatch, cur_mode is unchanged and err pulses.
REQ-028 The cycle after CHK: state IDLE, done=1, pix_hold=0.
REQ-029 Mode 11: accepted, no register access, no hold; done and err pulse the next cycle.
REQ-030 Hold duration shall be exactly 12 cycles for mode 10 and 3 cycles for modes 00/01.
REQ-031 reg_write_en shall be 0 in all states other than WR_KER and WR_MODE.
REQ-032 req_valid while not ready shall be ignored, with no effect on captured values.

Reset
REQ-033 On resetn low at a clock edge: state IDLE, counter 0, pix_hold 0, reg_write_en 0, reg_addr 0, reg_wdata 0, cur_mode 00, done 0, err 0.
REQ-034 Reset mid-sequence shall abort immediately and release pix_hold on the next edge, with no further register writes.

Structure
REQ-035 Package proc_cfg_pkg shall hold the state encoding, mode codes, ADDR_MODE=5'h00, ADDR_K0=5'h04, and NUM_TAPS=9.
REQ-036 The pixel counter shall be a sub-module frame_pos_counter (params IMG_WIDTH, IMG_HEIGHT; outputs count and last).

Verification
REQ-037 Idle at count 0, request mode 01 -> writes 0x01 to addr 0x00 in the next cycle; pix_hold high for 3 cycles; done; cur_mode=01.
REQ-038 Request mode 10 at count 100 with kernel {0,-1,0,-1,4,-1,0,-1,0} -> no writes until pixel 1023 is consumed; then addrs 0x04..0x0C get 00,FF,00,FF,04,FF,00,FF,00, then 0x02 to 0x00; hold 12 cycles.
REQ-039 Model returns rdata 0x00 after mode 10 is written -> err and done pulse together; cur_mode unchanged.
REQ-040 Request mode 11 -> no reg_write_en, no pix_hold; done and err pulse after 1 cycle.
REQ-041 Accept at count 0 with pix_valid high -> waits a full frame of 1024 pixels before writing.
REQ-042 Drop resetn during the 5th kernel write -> next cycle: pix_hold=0, reg_write_en=0, req_ready=1, cur_mode=00.
